// File: rtl/note_recorder.sv
// note_recorder: records keyboard note messages with tick deltas and replays them.
// Define NOTE_REC_LOOP_EN to make playback wrap to the first entry until aborted.
module note_recorder #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int DEPTH        = 256,
    parameter int TS_W         = 16,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    input  logic                         rec,
    input  logic                         play,
    input  logic                         clk_msg_in,
    input  logic [7:0]                   msg_in,
    output logic                         clk_msg_out,
    output logic [7:0]                   msg_out,
    output logic                         recording,
    output logic                         playing,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   length
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int PW    = $clog2(DIV);
    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int EW    = TS_W + 8;
    localparam int CW    = $clog2(2 * PULSE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_REC, S_FETCH, S_LOAD, S_WAIT, S_EMIT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic              ev_q, ev_d;
    logic [7:0]        mbuf_q, mbuf_d;
    logic [TS_W-1:0]   delta_q, delta_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ovf_q, ovf_d;
    logic [EW-1:0]     entry_q, entry_d;
    logic [TS_W-1:0]   wait_q, wait_d;
    logic [CW-1:0]     emit_q, emit_d;
    logic              clk_out_q, clk_out_d;
    logic [7:0]        msg_out_q, msg_out_d;
    logic              rec_q, rec_d, play_q, play_d;

    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     rdata_q;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic              tick, full, last, in_play;

    assign tick     = (pre_q == PW'(DIV - 1));
    assign full     = (len_q == LEN_W'(DEPTH));
    assign last     = ((LEN_W'(rd_ptr_q) + 1'b1) == len_q);
    assign in_play  = state_q inside {S_FETCH, S_LOAD, S_WAIT, S_EMIT};
    assign ram_addr = (state_q == S_REC) ? len_q[AW-1:0] : rd_ptr_q;
    assign ram_we   = (state_q == S_REC) && ev_q && !full;

    // Single-port buffer RAM with one-cycle registered read.
    always_ff @(posedge pclk) begin
        if (ram_we) mem[ram_addr] <= {delta_q, mbuf_q};
        rdata_q <= mem[ram_addr];
    end

    // Next-state logic: prescaler, event sync, record and playback sequencing.
    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? '0 : pre_q + 1'b1;
        sync1_d   = clk_msg_in;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        ev_d      = sync2_q & ~sync3_q;
        mbuf_d    = (sync2_q & ~sync3_q) ? msg_in : mbuf_q;
        delta_d   = delta_q;
        rd_ptr_d  = rd_ptr_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        entry_d   = entry_q;
        wait_d    = wait_q;
        emit_d    = emit_q;
        clk_out_d = clk_out_q;
        msg_out_d = msg_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (rec) begin
                    state_d = S_REC;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    delta_d = '0;
                    pre_d   = '0;
                end else if (play && len_q != '0) begin
                    state_d  = S_FETCH;
                    rd_ptr_d = '0;
                    pre_d    = '0;
                end
            end
            S_REC: begin
                if (rec) state_d = S_IDLE;
                if (ev_q && !full) begin
                    len_d   = len_q + 1'b1;
                    delta_d = '0;
                end else begin
                    if (ev_q) ovf_d = 1'b1;
                    if (tick && delta_q != '1) delta_d = delta_q + 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                entry_d = rdata_q;
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == entry_q[EW-1:8]) begin
                    msg_out_d = entry_q[7:0];
                    emit_d    = '0;
                    state_d   = S_EMIT;
                end else if (tick) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EMIT: begin
                clk_out_d = (emit_q < CW'(PULSE_CYCLES));
                emit_d    = emit_q + 1'b1;
                if (emit_q == CW'(2 * PULSE_CYCLES - 1)) begin
                    if (last) begin
`ifdef NOTE_REC_LOOP_EN
                        rd_ptr_d = '0;
                        pre_d    = '0;
                        state_d  = S_FETCH;
`else
                        state_d  = S_IDLE;
`endif
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (play && in_play) begin
            state_d   = S_IDLE;
            clk_out_d = 1'b0;
            msg_out_d = 8'h00;
        end
        rec_d  = (state_d == S_REC);
        play_d = state_d inside {S_FETCH, S_LOAD, S_WAIT, S_EMIT};
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            ev_q      <= 1'b0;
            mbuf_q    <= 8'h00;
            delta_q   <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            entry_q   <= '0;
            wait_q    <= '0;
            emit_q    <= '0;
            clk_out_q <= 1'b0;
            msg_out_q <= 8'h00;
            rec_q     <= 1'b0;
            play_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            ev_q      <= ev_d;
            mbuf_q    <= mbuf_d;
            delta_q   <= delta_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            entry_q   <= entry_d;
            wait_q    <= wait_d;
            emit_q    <= emit_d;
            clk_out_q <= clk_out_d;
            msg_out_q <= msg_out_d;
            rec_q     <= rec_d;
            play_q    <= play_d;
        end
    end

    assign clk_msg_out = clk_out_q;
    assign msg_out     = msg_out_q;
    assign recording   = rec_q;
    assign playing     = play_q;
    assign overflow    = ovf_q;
    assign length      = len_q;

endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed bench for note_recorder (10 cycles/tick, DEPTH=4).
// Expected cycle numbers are counted from the negedge following each rec/play pulse.
module tb_note_recorder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rec, play, clk_msg_in;
    logic [7:0] msg_in;
    logic       clk_msg_out;
    logic [7:0] msg_out;
    logic       recording, playing, overflow;
    logic [2:0] length;

    int checks = 0;
    int errors = 0;
    int n, w, rises;
    logic prev;
    logic [7:0] got [8];
    logic [7:0] m;

    note_recorder #(
        .CLK_FREQ(1000), .TICK_HZ(100), .DEPTH(4), .TS_W(16), .PULSE_CYCLES(4)
    ) dut (
        .pclk(clk), .rst_n(rst_n), .rec(rec), .play(play),
        .clk_msg_in(clk_msg_in), .msg_in(msg_in),
        .clk_msg_out(clk_msg_out), .msg_out(msg_out),
        .recording(recording), .playing(playing),
        .overflow(overflow), .length(length)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_rec();
        rec = 1'b1;
        @(negedge clk);
        rec = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        clk_msg_in = 1'b1;
        msg_in = v;
        cyc(3);
        clk_msg_in = 1'b0;
        cyc(3);
    endtask

    task automatic collect(input int limit, input int stop_after);
        rises = 0;
        n = 0;
        prev = 1'b0;
        while (playing === 1'b1 && n < limit && rises < stop_after) begin
            if (clk_msg_out === 1'b1 && prev === 1'b0) begin
                if (rises < 8) got[rises] = msg_out;
                rises++;
            end
            prev = clk_msg_out;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rec = 1'b0;
        play = 1'b0;
        clk_msg_in = 1'b0;
        msg_in = 8'h00;
        cyc(3);
        chk("rst_clk_out", clk_msg_out, 0);
        chk("rst_msg_out", msg_out, 8'h00);
        chk("rst_recording", recording, 0);
        chk("rst_playing", playing, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_length", length, 0);
        rst_n = 1'b1;
        cyc(2);

        // two events: delta 3 ticks, then 4 ticks
        pulse_rec();
        chk("rec_entered", recording, 1);
        cyc(31);
        clk_msg_in = 1'b1;
        msg_in = 8'h85;
        cyc(4);
        clk_msg_in = 1'b0;
        chk("len_after_ev1", length, 1);
        cyc(36);
        clk_msg_in = 1'b1;
        msg_in = 8'h05;
        cyc(4);
        clk_msg_in = 1'b0;
        cyc(5);
        pulse_rec();
        chk("rec_exit", recording, 0);
        chk("rec_length", length, 2);
        chk("rec_overflow", overflow, 0);
        chk("ram0", dut.mem[0], {16'd3, 8'h85});
        chk("ram1", dut.mem[1], {16'd4, 8'h05});

        // replay timing
        pulse_play();
        chk("play_flag", playing, 1);
        n = 0;
        while (clk_msg_out !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rise1_cycle", n, 32);
        chk("rise1_msg", msg_out, 8'h85);
        w = 0;
        while (clk_msg_out === 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
            n++;
        end
        chk("pulse_width", w, 4);
        while (clk_msg_out !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rise2_cycle", n, 82);
        chk("rise2_msg", msg_out, 8'h05);
        while (playing !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("play_end_cycle", n, 89);
        chk("play_end_clk", clk_msg_out, 0);

        // overflow: five events into four slots
        pulse_rec();
        for (int i = 0; i < 5; i++) begin
            m = 8'h81 + 8'(i);
            send(m);
        end
        cyc(4);
        pulse_rec();
        chk("ovf_length", length, 4);
        chk("ovf_flag", overflow, 1);
        pulse_play();
        collect(500, 8);
        chk("ovf_rises", rises, 4);
        chk("ovf_msg0", got[0], 8'h81);
        chk("ovf_msg1", got[1], 8'h82);
        chk("ovf_msg2", got[2], 8'h83);
        chk("ovf_msg3", got[3], 8'h84);

        // abort during PLAY_WAIT
        pulse_rec();
        chk("rec_clears_ovf", overflow, 0);
        cyc(31);
        clk_msg_in = 1'b1;
        msg_in = 8'h90;
        cyc(4);
        clk_msg_in = 1'b0;
        cyc(10);
        pulse_rec();
        chk("abort_len", length, 1);
        pulse_play();
        cyc(10);
        chk("abort_pre_playing", playing, 1);
        pulse_play();
        chk("abort_playing", playing, 0);
        chk("abort_msg", msg_out, 8'h00);
        chk("abort_clk", clk_msg_out, 0);
        rises = 0;
        for (int i = 0; i < 60; i++) begin
            if (clk_msg_out !== 1'b0) rises++;
            @(negedge clk);
        end
        chk("abort_no_edges", rises, 0);

        // rec and play together in IDLE
        rec = 1'b1;
        play = 1'b1;
        @(negedge clk);
        rec = 1'b0;
        play = 1'b0;
        chk("both_recording", recording, 1);
        chk("both_playing", playing, 0);
        chk("both_len_clear", length, 0);
        pulse_rec();

        // empty buffer: play ignored
        pulse_play();
        chk("empty_play", playing, 0);

`ifdef NOTE_REC_LOOP_EN
        pulse_rec();
        send(8'h85);
        send(8'h05);
        pulse_rec();
        pulse_play();
        collect(1000, 5);
        chk("loop_rises", rises, 5);
        chk("loop_m0", got[0], 8'h85);
        chk("loop_m1", got[1], 8'h05);
        chk("loop_m2", got[2], 8'h85);
        chk("loop_m3", got[3], 8'h05);
        chk("loop_m4", got[4], 8'h85);
        pulse_play();
        chk("loop_stop", playing, 0);
`endif

        // reset mid-emit on a delta-0 entry
        pulse_rec();
        send(8'h85);
        pulse_rec();
        pulse_play();
        n = 0;
        while (clk_msg_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d0_rise_cycle", n, 4);
        chk("d0_msg", msg_out, 8'h85);
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk", clk_msg_out, 0);
        chk("mid_rst_msg", msg_out, 8'h00);
        chk("mid_rst_playing", playing, 0);
        chk("mid_rst_len", length, 0);
        chk("mid_rst_rec", recording, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
